alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Parametrised execute-stage ALU for the SIWO core.
- Accepts one operation per handshake: function code, two operands and a destination tag. Returns a registered result, status flags and the tag over a valid/ready interface.
- Single-cycle ops complete in 1 cycle. Shift ops run iteratively, 1 bit per cycle, under a small FSM.
- Sits between decode/register read and writeback. Function encodings are the core's FUNC_* codes (FUNC_SET..FUNC_ABS = 0..14).

Parameters:
- DATA_WIDTH, 16, operand/result width (>=4, power of two)
- FUNC_WIDTH, 5, function code width
- TAG_WIDTH, 4, destination register tag width (matches REG_WIDTH)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation offered
- in_ready  output  1  unit can accept
- in_func  input  FUNC_WIDTH  function code
- in_a  input  DATA_WIDTH  operand A
- in_b  input  DATA_WIDTH  operand B / immediate / shift amount
- in_tag  input  TAG_WIDTH  destination tag, passed through
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_result  output  DATA_WIDTH  result
- out_tag  output  TAG_WIDTH  tag of result
- out_zero, out_neg, out_carry, out_ovf  output  1 each  status flags
- out_illegal  output  1  unsupported function code
- busy  output  1  shift in progress

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst_n is asynchronous, active-low.
  - In reset: out_valid=0, busy=0, FSM=IDLE. out_result, out_tag and all flags = 0.
- Handshake:
  - Input transfers when in_valid && in_ready. Output transfers when out_valid && out_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). Back-to-back single-cycle ops sustain 1 per cycle.
  - Output registers stay stable while out_valid && !out_ready.
- FSM states: IDLE, SHIFT.
  - IDLE, accept non-shift op: compute combinationally, register next cycle. out_valid=1 one cycle after acceptance.
  - IDLE, accept shift op (ULS/URS/SLS/SRS) with amount n = in_b[log2(DATA_WIDTH)-1:0]:
    - n==0: behaves as single-cycle, result = in_a.
    - n>0: latch A, n and func; go to SHIFT; busy=1.
  - SHIFT: shift 1 bit per cycle and decrement the counter. When the counter reaches 0, write the output registers, set out_valid, return to IDLE. Total latency n+1 cycles after acceptance.
  - Upper bits of in_b are ignored for shifts.
- Operations (A=in_a, B=in_b, modulo 2^DATA_WIDTH):
  - SET=B.
  - ADD=A+B; carry = carry-out; ovf = signed overflow.
  - SUB=A-B; carry = borrow (A<B unsigned); ovf = signed overflow.
  - ULS = logical left. URS = logical right.
  - SLS = left shift with MSB held (sign preserved).
  - SRS = arithmetic right.
  - AND/OR/XOR = bitwise. NOT = ~A.
  - LSS = signed A<B. EQL = A==B. GRT = signed A>B. Compare results are 1 or 0, zero-extended.
  - ABS = |A| signed; the most-negative value returns itself with ovf=1.
- Flags:
  - zero = (result==0); neg = result MSB.
  - carry and ovf are 0 for all ops other than ADD/SUB (ovf also set by ABS per above).
- Illegal codes (any code not listed, including 15..31 unless the optional feature is enabled):
  - result=0, out_illegal=1, other flags 0, latency 1.
- Reset asserted mid-shift: the in-flight op is discarded; no output is produced after release.
- Reset asserted while out_valid=1 and not accepted: that result is lost.

Optional Feature:
- Macro ALU_EXEC_MUL_EN.
- Defined: function code 5'b01111 (MUL) is legal. Single-cycle unsigned multiply; result = low DATA_WIDTH bits. carry=1 if the high half is nonzero.
- Undefined: code 5'b01111 is illegal (result 0, out_illegal=1) and no multiplier is synthesised.

Test Plan:
- ADD A=0x7FFF, B=0x0001 -> next cycle out_result=0x8000, neg=1, ovf=1, carry=0, zero=0; out_tag equals in_tag.
- SUB A=0x0000, B=0x0001 -> 0xFFFF, carry=1, ovf=0. SUB A=0x0005, B=0x0005 -> 0x0000, zero=1.
- SRS A=0x8000, B=0x0003 -> busy and in_ready=0 for 3 cycles; out_valid on cycle 4 with 0xF000. URS with the same A and B -> 0x1000. SLS A=0x8001, B=1 -> 0x8002.
- Backpressure: two back-to-back ADDs with out_ready=0 -> first result held stable, in_ready=0, second accepted only after out_ready=1.
- in_func=5'b11111 -> out_result=0, out_illegal=1. ABS A=0x8000 -> 0x8000, ovf=1.
- rst_n pulsed low mid-SHIFT -> out_valid=0 and busy=0 immediately, and no result appears after release. With ALU_EXEC_MUL_EN defined: MUL 0x0100*0x0100 -> 0x0000, zero=1, carry=1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle arithmetic/logic/compare ops and iterative 1-bit-per-cycle shifts.
// Optional unsigned multiply on function code 15 when ALU_EXEC_MUL_EN is defined.
module alu_exec_unit #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FUNC_WIDTH = 5,
    parameter int unsigned TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FUNC_WIDTH-1:0] in_func,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  out_zero,
    output logic                  out_neg,
    output logic                  out_carry,
    output logic                  out_ovf,
    output logic                  out_illegal,
    output logic                  busy
);

    localparam int unsigned SH_W = $clog2(DATA_WIDTH);
    localparam int unsigned MSB  = DATA_WIDTH - 1;

    localparam logic [FUNC_WIDTH-1:0] FUNC_SET = FUNC_WIDTH'(0);
    localparam logic [FUNC_WIDTH-1:0] FUNC_ADD = FUNC_WIDTH'(1);
    localparam logic [FUNC_WIDTH-1:0] FUNC_SUB = FUNC_WIDTH'(2);
    localparam logic [FUNC_WIDTH-1:0] FUNC_ULS = FUNC_WIDTH'(3);
    localparam logic [FUNC_WIDTH-1:0] FUNC_URS = FUNC_WIDTH'(4);
    localparam logic [FUNC_WIDTH-1:0] FUNC_SLS = FUNC_WIDTH'(5);
    localparam logic [FUNC_WIDTH-1:0] FUNC_SRS = FUNC_WIDTH'(6);
    localparam logic [FUNC_WIDTH-1:0] FUNC_AND = FUNC_WIDTH'(7);
    localparam logic [FUNC_WIDTH-1:0] FUNC_OR  = FUNC_WIDTH'(8);
    localparam logic [FUNC_WIDTH-1:0] FUNC_XOR = FUNC_WIDTH'(9);
    localparam logic [FUNC_WIDTH-1:0] FUNC_NOT = FUNC_WIDTH'(10);
    localparam logic [FUNC_WIDTH-1:0] FUNC_LSS = FUNC_WIDTH'(11);
    localparam logic [FUNC_WIDTH-1:0] FUNC_EQL = FUNC_WIDTH'(12);
    localparam logic [FUNC_WIDTH-1:0] FUNC_GRT = FUNC_WIDTH'(13);
    localparam logic [FUNC_WIDTH-1:0] FUNC_ABS = FUNC_WIDTH'(14);
`ifdef ALU_EXEC_MUL_EN
    localparam logic [FUNC_WIDTH-1:0] FUNC_MUL = FUNC_WIDTH'(15);
`endif

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic                  zero;
        logic                  neg;
        logic                  carry;
        logic                  ovf;
        logic                  illegal;
    } res_t;

    state_t                r_state;
    state_t                w_state_nxt;
    res_t                  r_out;
    res_t                  w_alu;
    res_t                  w_out_nxt;
    logic                  r_out_valid;
    logic                  r_busy;
    logic [TAG_WIDTH-1:0]  r_out_tag;
    logic [TAG_WIDTH-1:0]  w_tag_nxt;
    logic [TAG_WIDTH-1:0]  r_sh_tag;
    logic [DATA_WIDTH-1:0] r_sh_val;
    logic [DATA_WIDTH-1:0] w_sh_step;
    logic [SH_W-1:0]       r_sh_cnt;
    logic [FUNC_WIDTH-1:0] r_sh_func;
    logic                  w_accept;
    logic                  w_is_shift;
    logic                  w_out_load;
    logic                  w_sh_load;
    logic                  w_sh_adv;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_dif;
    logic [DATA_WIDTH-1:0] w_neg_a;
`ifdef ALU_EXEC_MUL_EN
    logic [2*DATA_WIDTH-1:0] w_prod;
`endif

    // Result with zero/neg derived from the value; carry/ovf/illegal cleared.
    function automatic res_t make_res(input logic [DATA_WIDTH-1:0] r);
        res_t v;
        v         = '0;
        v.result  = r;
        v.zero    = (r == '0);
        v.neg     = r[MSB];
        return v;
    endfunction

    // Single-cycle datapath; shifts here only cover the zero-amount case.
    always_comb begin
        w_sum   = {1'b0, in_a} + {1'b0, in_b};
        w_dif   = {1'b0, in_a} - {1'b0, in_b};
        w_neg_a = -in_a;
`ifdef ALU_EXEC_MUL_EN
        w_prod  = {DATA_WIDTH'(0), in_a} * {DATA_WIDTH'(0), in_b};
`endif
        w_alu   = '0;
        case (in_func)
            FUNC_SET: w_alu = make_res(in_b);
            FUNC_ADD: begin
                w_alu       = make_res(w_sum[MSB:0]);
                w_alu.carry = w_sum[DATA_WIDTH];
                w_alu.ovf   = (in_a[MSB] == in_b[MSB]) && (w_sum[MSB] != in_a[MSB]);
            end
            FUNC_SUB: begin
                w_alu       = make_res(w_dif[MSB:0]);
                w_alu.carry = w_dif[DATA_WIDTH];
                w_alu.ovf   = (in_a[MSB] != in_b[MSB]) && (w_dif[MSB] != in_a[MSB]);
            end
            FUNC_ULS, FUNC_URS, FUNC_SLS, FUNC_SRS: w_alu = make_res(in_a);
            FUNC_AND: w_alu = make_res(in_a & in_b);
            FUNC_OR:  w_alu = make_res(in_a | in_b);
            FUNC_XOR: w_alu = make_res(in_a ^ in_b);
            FUNC_NOT: w_alu = make_res(~in_a);
            FUNC_LSS: w_alu = make_res(DATA_WIDTH'($signed(in_a) < $signed(in_b)));
            FUNC_EQL: w_alu = make_res(DATA_WIDTH'(in_a == in_b));
            FUNC_GRT: w_alu = make_res(DATA_WIDTH'($signed(in_a) > $signed(in_b)));
            FUNC_ABS: begin
                // Negating the most-negative value wraps to itself and flags overflow.
                w_alu     = make_res(in_a[MSB] ? w_neg_a : in_a);
                w_alu.ovf = in_a[MSB] && w_neg_a[MSB];
            end
`ifdef ALU_EXEC_MUL_EN
            FUNC_MUL: begin
                w_alu       = make_res(w_prod[MSB:0]);
                w_alu.carry = |w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
            end
`endif
            default:  w_alu.illegal = 1'b1;
        endcase
    end

    // One-bit shift step applied to the latched operand.
    always_comb begin
        w_sh_step = r_sh_val;
        case (r_sh_func)
            FUNC_ULS: w_sh_step = {r_sh_val[MSB-1:0], 1'b0};
            FUNC_URS: w_sh_step = {1'b0, r_sh_val[MSB:1]};
            FUNC_SLS: w_sh_step = {r_sh_val[MSB], r_sh_val[MSB-2:0], 1'b0};
            FUNC_SRS: w_sh_step = {r_sh_val[MSB], r_sh_val[MSB:1]};
            default:  w_sh_step = r_sh_val;
        endcase
    end

    // Next-state and handshake control.
    always_comb begin
        w_state_nxt = r_state;
        w_out_load  = 1'b0;
        w_sh_load   = 1'b0;
        w_sh_adv    = 1'b0;
        w_out_nxt   = w_alu;
        w_tag_nxt   = in_tag;
        w_is_shift  = (in_func == FUNC_ULS) || (in_func == FUNC_URS) ||
                      (in_func == FUNC_SLS) || (in_func == FUNC_SRS);
        in_ready    = (r_state == S_IDLE) && (!r_out_valid || out_ready);
        w_accept    = in_valid && in_ready;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_shift && (in_b[SH_W-1:0] != '0)) begin
                        w_sh_load   = 1'b1;
                        w_state_nxt = S_SHIFT;
                    end else begin
                        w_out_load  = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                w_sh_adv = 1'b1;
                // Last step writes straight to the output so latency is amount+1.
                if (r_sh_cnt == SH_W'(1)) begin
                    w_out_load  = 1'b1;
                    w_out_nxt   = make_res(w_sh_step);
                    w_tag_nxt   = r_sh_tag;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_SHIFT);
        end
    end

    // Output register holds its value while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_tag   <= '0;
            r_out_valid <= 1'b0;
        end else if (w_out_load) begin
            r_out       <= w_out_nxt;
            r_out_tag   <= w_tag_nxt;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_val  <= '0;
            r_sh_cnt  <= '0;
            r_sh_func <= '0;
            r_sh_tag  <= '0;
        end else if (w_sh_load) begin
            r_sh_val  <= in_a;
            r_sh_cnt  <= in_b[SH_W-1:0];
            r_sh_func <= in_func;
            r_sh_tag  <= in_tag;
        end else if (w_sh_adv) begin
            r_sh_val  <= w_sh_step;
            r_sh_cnt  <= r_sh_cnt - SH_W'(1);
        end
    end

    assign out_valid   = r_out_valid;
    assign out_result  = r_out.result;
    assign out_tag     = r_out_tag;
    assign out_zero    = r_out.zero;
    assign out_neg     = r_out.neg;
    assign out_carry   = r_out.carry;
    assign out_ovf     = r_out.ovf;
    assign out_illegal = r_out.illegal;
    assign busy        = r_busy;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: driver pushes model results, monitor pops and compares.
module tb_alu_exec_unit;

    localparam int unsigned W  = 16;
    localparam int unsigned FW = 5;
    localparam int unsigned TW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] in_func;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [TW-1:0] out_tag;
    logic          out_zero;
    logic          out_neg;
    logic          out_carry;
    logic          out_ovf;
    logic          out_illegal;
    logic          busy;

    alu_exec_unit #(.DATA_WIDTH(W), .FUNC_WIDTH(FW), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_zero(out_zero), .out_neg(out_neg),
        .out_carry(out_carry), .out_ovf(out_ovf), .out_illegal(out_illegal),
        .busy(busy)
    );

    typedef struct {
        logic [W-1:0]  res;
        logic          z, n, c, v, ill;
        logic [TW-1:0] tag;
        int            lat;
        int            acc;
    } exp_t;

    exp_t sb[$];
    int   n_chk;
    int   n_fail;
    int   cyc;
    int   rdy_mode;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model from the instruction definitions, using plain integer arithmetic.
    function automatic exp_t model(input logic [FW-1:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int ua, ub, sa, sb_, r, n;
`ifdef ALU_EXEC_MUL_EN
        longint p;
`endif
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb_ = (ub >= 32768) ? ub - 65536 : ub;
        n  = ub % 16;
        r  = 0;
        e  = '{default: 0};
        e.lat = 1;
        case (int'(f))
            0:  r = ub;
            1:  begin r = ua + ub; e.c = (r > 65535); e.v = (sa + sb_ > 32767) || (sa + sb_ < -32768); end
            2:  begin r = ua - ub; e.c = (ua < ub);   e.v = (sa - sb_ > 32767) || (sa - sb_ < -32768); end
            3:  r = ua << n;
            4:  r = ua >> n;
            5:  r = (ua & 'h8000) | ((ua << n) & 'h7FFF);
            6:  r = sa >>> n;
            7:  r = ua & ub;
            8:  r = ua | ub;
            9:  r = ua ^ ub;
            10: r = ~ua;
            11: r = (sa < sb_) ? 1 : 0;
            12: r = (ua == ub) ? 1 : 0;
            13: r = (sa > sb_) ? 1 : 0;
            14: begin r = (sa < 0) ? -sa : sa; e.v = (sa == -32768); end
`ifdef ALU_EXEC_MUL_EN
            15: begin p = longint'(ua) * longint'(ub); r = int'(p & 64'hFFFF); e.c = ((p >> 16) != 0); end
`endif
            default: e.ill = 1'b1;
        endcase
        if (int'(f) >= 3 && int'(f) <= 6 && n > 0) e.lat = n + 1;
        if (!e.ill) begin
            e.res = r[15:0];
            e.z   = (e.res == 16'h0000);
            e.n   = e.res[15];
        end
        return e;
    endfunction

    // Drive one op, wait (bounded) for acceptance, record expectation; optionally watch busy.
    task automatic issue(input logic [FW-1:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] t, input bit chk_busy, output int waited);
        exp_t e;
        bit   acc;
        int   n;
        e     = model(f, a, b);
        e.tag = t;
        acc   = 1'b0;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1; in_func = f; in_a = a; in_b = b; in_tag = t;
        for (int k = 0; k < 200; k++) begin
            #4;
            if (in_ready) begin
                acc   = 1'b1;
                e.acc = cyc;
                sb.push_back(e);
                break;
            end
            waited++;
            @(negedge clk);
        end
        chk("accept_timeout", 32'(acc), 32'd1);
        if (acc) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n = int'(b[3:0]);
        if (acc && chk_busy && int'(f) >= 3 && int'(f) <= 6 && n > 0) begin
            for (int k = 1; k <= n; k++) begin
                @(negedge clk); #4;
                chk("busy_during_shift", 32'(busy), 32'd1);
                chk("in_ready_during_shift", 32'(in_ready), 32'd0);
            end
            @(negedge clk); #4;
            chk("busy_cleared", 32'(busy), 32'd0);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 500; k++) begin
            @(negedge clk); #4;
            if (sb.size() == 0 && !out_valid) break;
        end
        chk("drain_queue_empty", 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 9))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Monitor: compares each new result against the queue head, checks stability while stalled.
    initial begin : monitor
        exp_t        e;
        logic        holding;
        logic [24:0] held;
        holding   = 1'b0;
        held      = '0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
            #4;
            if (!rst_n || !out_valid) begin
                holding = 1'b0;
            end else begin
                if (!holding) begin
                    chk("output_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb[0];
                        chk("result",  32'(out_result),  32'(e.res));
                        chk("zero",    32'(out_zero),    32'(e.z));
                        chk("neg",     32'(out_neg),     32'(e.n));
                        chk("carry",   32'(out_carry),   32'(e.c));
                        chk("ovf",     32'(out_ovf),     32'(e.v));
                        chk("illegal", 32'(out_illegal), 32'(e.ill));
                        chk("tag",     32'(out_tag),     32'(e.tag));
                        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                    end
                end else begin
                    chk("hold_stable", 32'({out_result, out_zero, out_neg, out_carry, out_ovf,
                                            out_illegal, out_tag}), 32'(held));
                end
                if (out_ready) begin
                    if (sb.size() != 0) void'(sb.pop_front());
                    holding = 1'b0;
                end else begin
                    holding = 1'b1;
                    held = {out_result, out_zero, out_neg, out_carry, out_ovf, out_illegal, out_tag};
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int            w0, w1;
        logic [FW-1:0] f;
        n_chk = 0; n_fail = 0; cyc = 0; rdy_mode = 1;
        rst_n = 1'b0; in_valid = 1'b0; in_func = '0; in_a = '0; in_b = '0; in_tag = '0;
        repeat (3) @(negedge clk);
        #4;
        chk("rst_out_valid", 32'(out_valid),  32'd0);
        chk("rst_busy",      32'(busy),       32'd0);
        chk("rst_result",    32'(out_result), 32'd0);
        chk("rst_tag",       32'(out_tag),    32'd0);
        chk("rst_flags",     32'({out_zero, out_neg, out_carry, out_ovf, out_illegal}), 32'd0);
        chk("rst_in_ready",  32'(in_ready),   32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        issue(5'd1,  16'h7FFF, 16'h0001, 4'h5, 1'b1, w0);
        issue(5'd2,  16'h0000, 16'h0001, 4'h6, 1'b1, w0);
        issue(5'd2,  16'h0005, 16'h0005, 4'h7, 1'b1, w0);
        issue(5'd6,  16'h8000, 16'h0003, 4'h8, 1'b1, w0);
        issue(5'd4,  16'h8000, 16'h0003, 4'h9, 1'b1, w0);
        issue(5'd5,  16'h8001, 16'h0001, 4'hA, 1'b1, w0);
        issue(5'd3,  16'h1234, 16'hFFF0, 4'hB, 1'b1, w0);
        issue(5'd31, 16'h1234, 16'h5678, 4'hC, 1'b1, w0);
        issue(5'd14, 16'h8000, 16'h0000, 4'hD, 1'b1, w0);
        issue(5'd15, 16'h0100, 16'h0100, 4'hE, 1'b1, w0);

        // Back-to-back single-cycle ops must not stall.
        issue(5'd9,  16'hA5A5, 16'h0FF0, 4'h1, 1'b1, w0);
        issue(5'd11, 16'h8000, 16'h0001, 4'h2, 1'b1, w1);
        chk("back_to_back_no_stall", 32'(w1), 32'd0);

        // Backpressure: second op held off while first result is stalled.
        drain();
        rdy_mode = 2;
        issue(5'd1, 16'h1111, 16'h2222, 4'h3, 1'b1, w0);
        @(negedge clk);
        in_valid = 1'b1; in_func = 5'd1; in_a = 16'h0F0F; in_b = 16'hF0F1; in_tag = 4'h4;
        for (int k = 0; k < 4; k++) begin
            #4;
            chk("bp_in_ready_low", 32'(in_ready),  32'd0);
            chk("bp_out_valid",    32'(out_valid), 32'd1);
            @(negedge clk);
        end
        rdy_mode = 1;
        issue(5'd1, 16'h0F0F, 16'hF0F1, 4'h4, 1'b1, w0);
        drain();

        // Reset in the middle of a shift discards it.
        issue(5'd6, 16'h8000, 16'h000F, 4'h9, 1'b0, w0);
        repeat (4) @(negedge clk);
        chk("busy_before_reset", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_shift_out_valid", 32'(out_valid), 32'd0);
        chk("reset_shift_busy",      32'(busy),      32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #4;
            chk("no_output_after_reset", 32'(out_valid), 32'd0);
        end
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);

        // Reset while a result is stalled loses it.
        rdy_mode = 2;
        issue(5'd1, 16'h0001, 16'h0001, 4'h5, 1'b1, w0);
        @(negedge clk); #4;
        chk("stalled_before_reset", 32'(out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_held_out_valid", 32'(out_valid),  32'd0);
        chk("reset_held_result",    32'(out_result), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #4;
            chk("no_output_after_reset2", 32'(out_valid), 32'd0);
        end

        // Randomized traffic with random then steady consumer readiness.
        rdy_mode = 0;
        for (int i = 0; i < 300; i++) begin
            if (i == 200) rdy_mode = 1;
            if ($urandom_range(0, 9) < 8) f = FW'($urandom_range(0, 14));
            else                          f = FW'($urandom_range(15, 31));
            issue(f, pick(), pick(), TW'($urandom), 1'b1, w0);
        end
        rdy_mode = 1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
